// File: rtl/ddr_chart_pkg.sv
// Shared types and constants for the note-chart playback path.
package ddr_chart_pkg;

  // Arrow bit positions inside a chart word.
  localparam int arrow_left  = 0;
  localparam int arrow_down  = 1;
  localparam int arrow_up    = 2;
  localparam int arrow_right = 3;

  // Widest chart index a note event can carry; narrower charts zero-extend.
  localparam int step_w = 16;

  // End-of-chart marker always sits in the top bit of the chart word.
  function automatic int end_bit(input int width);
    return width - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0]        notes;
    logic [step_w-1:0] step;
  } note_evt_t;

endpackage

// File: rtl/step_timer.sv
// Free-running tick counter with enable/clear; tc pulses on the last tick of
// each period and the count wraps to zero on that same cycle.
module step_timer #(
  parameter int max_p = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int cnt_w = $clog2(max_p);
  localparam logic [cnt_w-1:0] last = cnt_w'(max_p - 1);

  logic [cnt_w-1:0] count;

  assign tc = en && !clr && (count == last);

  // Count enabled cycles, wrapping at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == last) ? '0 : count + cnt_w'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Steps through the note-chart ROM at a fixed tempo and hands arrow events to
// the judge/scroll pipeline. Game time never waits for the consumer: a note
// that arrives while the previous one is still pending is dropped and flagged.
// width_p must be at least 6 (arrows, reserved bits, end marker).
module chart_sequencer
  import ddr_chart_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int depth_p          = 128,
  parameter int ticks_per_step_p = 1000000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       pause_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [3:0]                 notes_o,
  output logic [$clog2(depth_p)-1:0] step_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  localparam int addr_w = $clog2(depth_p);
  localparam int eb     = end_bit(width_p);
  localparam logic [addr_w-1:0] last_addr = addr_w'(depth_p - 1);

  state_t     state, state_n;
  note_evt_t  pend;
  logic       strobe, start_go, run_en, tmr_clr;
  logic       end_hit, last_hit, has_notes, slot_free, load, drop;
  logic [3:0] field;
  logic       unused_bits;

  assign field     = rom_data_i[arrow_right:arrow_left];
  assign end_hit   = rom_data_i[eb];
  assign last_hit  = (rom_addr_o == last_addr);
  assign has_notes = |field;
  assign slot_free = !valid_o || ready_i;
  assign load      = strobe && !end_hit && has_notes && slot_free;
  assign drop      = strobe && !end_hit && has_notes && !slot_free;

  assign run_en  = (state == RUN) && !pause_i;
  assign tmr_clr = (state != RUN);

  assign notes_o = pend.notes;
  assign step_o  = pend.step[addr_w-1:0];

  // Reserved chart bits and the zero-extended top of the step field carry no
  // information here.
  assign unused_bits = ^{rom_data_i[eb-1:4], pend.step[step_w-1:addr_w]};

  step_timer #(
    .max_p(ticks_per_step_p)
  ) u_step_timer (
    .clk(clk_i),
    .rst(reset_i),
    .en (run_en),
    .clr(tmr_clr),
    .tc (strobe)
  );

  // Next-state: start only outside RUN; leave RUN on end marker or last entry.
  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n  = RUN;
          start_go = 1'b1;
        end
      end
      RUN: begin
        if (strobe && (end_hit || last_hit)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_n;
      busy_o <= (state_n == RUN);
      done_o <= (state_n == DONE);
    end
  end

  // Chart address: rewinds on start, advances per non-end step, never wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rom_addr_o <= '0;
    end else if (start_go) begin
      rom_addr_o <= '0;
    end else if (strobe && !end_hit && !last_hit) begin
      rom_addr_o <= rom_addr_o + addr_w'(1);
    end
  end

  // Sticky drop flag, cleared when a new run starts.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overrun_o <= 1'b0;
    end else if (start_go) begin
      overrun_o <= 1'b0;
    end else if (drop) begin
      overrun_o <= 1'b1;
    end
  end

  // Pending note slot; a strobe may refill it in the same cycle it is taken.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      pend    <= '0;
    end else if (load) begin
      valid_o    <= 1'b1;
      pend.notes <= field;
      pend.step  <= step_w'(rom_addr_o);
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
